// File: rtl/gpio_arb_pkg.sv
// rtl/gpio_arb_pkg.sv - shared state type, limits and round-robin helper for gpio_bus_arbiter
package gpio_arb_pkg;

  // Upper bound on requesters; grant_id is 2 bits wide.
  localparam int GPIO_ARB_MAX_REQ = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  // Index following idx, wrapping modulo num.
  function automatic logic [1:0] rr_next(input logic [1:0] idx, input int num);
    int n;
    n = int'(idx) + 1;
    if (n >= num) n = 0;
    return 2'(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin winner select; GPIO_ARB_FIXED_PRIO_EN gives requester 0 absolute priority
module rr_pick
  import gpio_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         ptr,
  output logic [1:0]         winner,
  output logic               valid
);

  // Number of requesters sharing the round-robin ring in fixed-priority mode.
  localparam int NUM_OTHERS = (NUM_REQ > 1) ? NUM_REQ - 1 : 1;

  // Walk the ring starting at ptr and take the first active request.
  always_comb begin
    int idx;
    int p;
    idx    = 0;
    p      = 0;
    winner = '0;
    valid  = 1'b0;
`ifdef GPIO_ARB_FIXED_PRIO_EN
    if (req[0]) begin
      valid = 1'b1;
    end else begin
      // ptr never names 0 in this mode except straight out of reset; treat that as 1.
      p = (ptr == 2'd0) ? 1 : int'(ptr);
      for (int k = 0; k < NUM_REQ - 1; k++) begin
        idx = 1 + ((p - 1 + k) % NUM_OTHERS);
        if (!valid && |(req & (NUM_REQ'(1) << idx))) begin
          winner = 2'(idx);
          valid  = 1'b1;
        end
      end
    end
`else
    p = int'(ptr);
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (p + k) % NUM_REQ;
      if (!valid && |(req & (NUM_REQ'(1) << idx))) begin
        winner = 2'(idx);
        valid  = 1'b1;
      end
    end
`endif
  end

endmodule

// File: rtl/gpio_bus_arbiter.sv
// rtl/gpio_bus_arbiter.sv - shares the decoder register bus among NUM_REQ requesters; GPIO_ARB_FIXED_PRIO_EN selects fixed priority for requester 0
module gpio_bus_arbiter
  import gpio_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int AddrWidth  = 16,
  parameter int BusWidth   = 32,
  parameter int RD_LATENCY = 4,
  parameter int WR_LATENCY = 3
) (
  input  logic                               clk,
  input  logic                               reset_in,
  input  logic [NUM_REQ-1:0]                 req,
  input  logic [NUM_REQ-1:0]                 we,
  input  logic [NUM_REQ-1:0][AddrWidth-1:0]  addr,
  input  logic [NUM_REQ-1:0][BusWidth-1:0]   wdata,
  output logic [NUM_REQ-1:0]                 ack,
  output logic [BusWidth-1:0]                rdata,
  output logic [1:0]                         grant_id,
  output logic                               busy,
  output logic                               bus_read,
  output logic                               bus_write,
  output logic [AddrWidth-1:0]               bus_address,
  output logic [BusWidth-1:0]                bus_wdata,
  input  logic [BusWidth-1:0]                bus_rdata
);

  localparam int CntWidth = 8;

  generate
    if (NUM_REQ < 1 || NUM_REQ > GPIO_ARB_MAX_REQ) begin : g_bad_num_req
      $error("gpio_bus_arbiter: NUM_REQ must be in 1..%0d", GPIO_ARB_MAX_REQ);
    end
    if (RD_LATENCY < 1 || RD_LATENCY > 256 || WR_LATENCY < 1 || WR_LATENCY > 256) begin : g_bad_latency
      $error("gpio_bus_arbiter: RD_LATENCY and WR_LATENCY must be in 1..256");
    end
  endgenerate

  arb_state_t           state;
  arb_state_t           state_nxt;
  logic [1:0]           ptr;
  logic [1:0]           ptr_nxt;
  logic [CntWidth-1:0]  cnt;
  logic                 we_r;
  logic [1:0]           pick_id;
  logic                 pick_valid;
  logic                 sel_we;
  logic [AddrWidth-1:0] sel_addr;
  logic [BusWidth-1:0]  sel_wdata;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (pick_id),
    .valid  (pick_valid)
  );

  // Route the round-robin winner's command fields.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_id == 2'(i)) begin
        sel_we    = we[i];
        sel_addr  = addr[i];
        sel_wdata = wdata[i];
      end
    end
  end

  // Pointer advances past the requester just served; fixed-priority mode never parks it on 0.
  always_comb begin
    ptr_nxt = rr_next(grant_id, NUM_REQ);
`ifdef GPIO_ARB_FIXED_PRIO_EN
    if (ptr_nxt == 2'd0 && NUM_REQ > 1) ptr_nxt = 2'd1;
`endif
  end

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state and strobe/ack decode; outputs follow state so reset drops them at once.
  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    bus_read  = 1'b0;
    bus_write = 1'b0;
    ack       = '0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (pick_valid) state_nxt = ISSUE;
      end
      ISSUE: begin
        bus_read  = ~we_r;
        bus_write = we_r;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        ack       = NUM_REQ'(1) << grant_id;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the granted command, count out the decoder latency, capture read data.
  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      grant_id    <= '0;
      ptr         <= '0;
      cnt         <= '0;
      we_r        <= 1'b0;
      bus_address <= '0;
      bus_wdata   <= '0;
      rdata       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant_id    <= pick_id;
            we_r        <= sel_we;
            bus_address <= {sel_addr[AddrWidth-1:2], 2'b00};
            bus_wdata   <= sel_wdata;
          end
        end
        ISSUE: begin
          cnt <= we_r ? CntWidth'(WR_LATENCY - 1) : CntWidth'(RD_LATENCY - 1);
        end
        WAIT: begin
          if (cnt == '0) begin
            if (!we_r) rdata <= bus_rdata;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          ptr <= ptr_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule
